// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    // Default operand width in bits
    localparam int DEFAULT_WIDTH = 8;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fa_cell.sv
// Full adder made of two half adders, with an OR gate merging their carries.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    ha_cell u_ha0 (
        .x (a),
        .y (b),
        .s (s0),
        .c (c0)
    );

    ha_cell u_ha1 (
        .x (s0),
        .y (cin),
        .s (sum),
        .c (c1)
    );

    assign cout = c0 | c1;

endmodule

// File: rtl/ha_cell.sv
// Half adder: building block for the full-adder cell.
module ha_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds a + b + cin one bit per clock, LSB first, using a
// single full-adder cell. The result appears with a one-cycle done pulse and
// is held until the next accepted start.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N);

    state_e        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          cell_sum;
    logic          cell_cout;

    fa_cell u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    // Next-state and datapath update; every register holds unless its state acts on it
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d   = {cell_sum, sum_q[N-1:1]};
                a_d     = {1'b0, a_q[N-1:1]};
                b_d     = {1'b0, b_q[N-1:1]};
                carry_d = cell_cout;
                if (cnt_q == CW'(N - 1)) begin
                    cout_d  = cell_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = (state_q == ADD) || (state_q == DONE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected results,
// a monitor pops and compares them on every done pulse.
module tb_serial_adder;

    localparam int N = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a     = '0;
    logic [N-1:0] b     = '0;
    logic         cin   = 1'b0;
    logic [N-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        int           done_cyc;
        string        name;
    } exp_t;

    exp_t         exp_q[$];
    int           done_log[$];
    int           cyc        = 0;
    int           checks     = 0;
    int           errors     = 0;
    bit           hold_valid = 1'b0;
    logic [N-1:0] hold_sum   = '0;
    logic         hold_cout  = 1'b0;

    serial_adder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Edge counter used for latency bookkeeping
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare each done pulse against the scoreboard, then watch the held result
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            done_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                check_output("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_output({e.name, "_sum"}, 32'(sum), 32'(e.sum));
                check_output({e.name, "_cout"}, 32'(cout), 32'(e.cout));
                check_output({e.name, "_latency"}, cyc, e.done_cyc);
                hold_sum   = e.sum;
                hold_cout  = e.cout;
                hold_valid = 1'b1;
            end
        end else if (rst_n && !busy && hold_valid) begin
            check_output("hold_sum", 32'(sum), 32'(hold_sum));
            check_output("hold_cout", 32'(cout), 32'(hold_cout));
        end
    end

    // Issue one operation and scramble the operand inputs while it runs
    task automatic apply_stimulus(input logic [N-1:0] av, input logic [N-1:0] bv, input logic ci,
                                  input logic [N-1:0] es, input logic ec, input string name,
                                  output int acc);
        exp_t e;
        @(negedge clk);
        a     = av;
        b     = bv;
        cin   = ci;
        start = 1'b1;
        acc   = cyc + 1;
        e.sum      = es;
        e.cout     = ec;
        e.done_cyc = acc + N;
        e.name     = name;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        cin   = ~ci;
        check_output({name, "_busy"}, 32'(busy), 1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output({name, "_drain"}, exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int c;
        logic [N-1:0] va[3];
        logic [N-1:0] vb[3];
        logic         vc[3];
        logic [N:0]   full;
        exp_t         e;

        // Reset state
        #12;
        check_output("reset_sum", 32'(sum), 0);
        check_output("reset_cout", 32'(cout), 0);
        check_output("reset_busy", 32'(busy), 0);
        check_output("reset_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-computed results
        apply_stimulus(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero", acc);
        wait_drain("zero");
        apply_stimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_plus_1", acc);
        wait_drain("ff_plus_1");
        apply_stimulus(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5_5a_cin", acc);
        wait_drain("a5_5a_cin");
        apply_stimulus(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "7f_plus_1", acc);
        wait_drain("7f_plus_1");

        // Start pulses during ADD and during DONE are ignored
        apply_stimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "ignore", acc);
        while (cyc < acc + 2) @(negedge clk);
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h11;
        @(negedge clk);
        start = 1'b0;
        while (cyc < acc + N) @(negedge clk);
        start = 1'b1;
        a     = 8'h22;
        b     = 8'h22;
        @(negedge clk);
        start = 1'b0;
        check_output("ignore_idle_after_done", 32'(busy), 0);
        repeat (N + 4) @(negedge clk);
        wait_drain("ignore");

        // Reset in the fourth ADD cycle aborts the operation
        apply_stimulus(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, "abort", acc);
        while (cyc < acc + 3) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        hold_valid = 1'b0;
        #1;
        check_output("abort_sum", 32'(sum), 0);
        check_output("abort_cout", 32'(cout), 0);
        check_output("abort_busy", 32'(busy), 0);
        check_output("abort_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 4) @(negedge clk);
        apply_stimulus(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, "after_reset", acc);
        wait_drain("after_reset");

        // Start held high for three back-to-back operations
        va[0] = 8'h10; vb[0] = 8'h20; vc[0] = 1'b0;
        va[1] = 8'hF0; vb[1] = 8'h20; vc[1] = 1'b1;
        va[2] = 8'h55; vb[2] = 8'hAA; vc[2] = 1'b0;
        done_log.delete();
        @(negedge clk);
        c     = cyc;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            while (cyc < c + (N + 2) * i) @(negedge clk);
            a    = va[i];
            b    = vb[i];
            cin  = vc[i];
            full = {1'b0, va[i]} + {1'b0, vb[i]} + {{N{1'b0}}, vc[i]};
            e.sum      = full[N-1:0];
            e.cout     = full[N];
            e.done_cyc = c + 1 + (N + 2) * i + N;
            e.name     = "held";
            exp_q.push_back(e);
        end
        while (cyc < c + 2 * (N + 2) + 1) @(negedge clk);
        start = 1'b0;
        wait_drain("held");
        check_output("held_done_count", done_log.size(), 3);
        if (done_log.size() == 3) begin
            check_output("held_spacing_1", done_log[1] - done_log[0], N + 2);
            check_output("held_spacing_2", done_log[2] - done_log[1], N + 2);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
